// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: push channel carrying completed results from the execute stage into the writeback queue
interface regfile_writeback_if #(
   parameter int width = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_addr;
   logic [width-1:0] in_data;
   modport master (output in_valid, in_addr, in_data, input in_ready);
   modport slave  (input in_valid, in_addr, in_data, output in_ready);
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order result queue draining onto the register file write port; forwarding of pending values enabled by REGFILE_WB_BYPASS_EN
module regfile_writeback #(
   parameter int width = 32,
   parameter int depth = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_writeback_if.slave     in_bus,
   input  logic                   wr_hold,
   output logic                   WrEn,
   output logic [4:0]             Aw,
   output logic [width-1:0]       Dw,
   input  logic [4:0]             Rs,
   input  logic [4:0]             Rt,
   output logic                   hit_a,
   output logic                   hit_b,
   output logic [width-1:0]       byp_a,
   output logic [width-1:0]       byp_b,
   output logic [$clog2(depth):0] count
);
   localparam int pw = $clog2(depth);
   localparam logic [pw:0] full_cnt = (pw+1)'(depth);
   logic [pw-1:0]    wr_ptr, rd_ptr;
   logic [4:0]       q_addr [depth];
   logic [width-1:0] q_data [depth];
   logic             push, pop;
   // Full refuses input regardless of a same-cycle pop; r0 writes complete the handshake but are dropped
   assign in_bus.in_ready = (count != full_cnt);
   assign push = in_bus.in_valid && in_bus.in_ready && (in_bus.in_addr != 5'd0);
   assign pop  = (count != '0) && !wr_hold;
   // Queue storage written at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= in_bus.in_addr;
         q_data[wr_ptr] <= in_bus.in_data;
      end
   end
   // Pointers, occupancy and the registered write port; Aw/Dw hold when no pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         WrEn   <= 1'b0;
         Aw     <= '0;
         Dw     <= '0;
      end else begin
         WrEn  <= pop;
         count <= count + (pw+1)'(push) - (pw+1)'(pop);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            Aw     <= q_addr[rd_ptr];
            Dw     <= q_data[rd_ptr];
         end
      end
   end
`ifdef REGFILE_WB_BYPASS_EN
   // Youngest match wins: output stage first, then queue entries oldest to newest overriding
   function automatic logic [width:0] lookup(input logic [4:0] r);
      logic [width:0] res;
      logic [pw-1:0]  idx;
      res = '0;
      if (r != 5'd0) begin
         if (WrEn && Aw == r) res = {1'b1, Dw};
         for (int i = 0; i < depth; i++) begin
            idx = rd_ptr + pw'(i);
            if (i < int'(count) && q_addr[idx] == r) res = {1'b1, q_data[idx]};
         end
      end
      return res;
   endfunction
   assign {hit_a, byp_a} = lookup(Rs);
   assign {hit_b, byp_b} = lookup(Rt);
`else
   logic unused_rd;
   assign unused_rd = ^{Rs, Rt};
   assign hit_a = 1'b0;
   assign hit_b = 1'b0;
   assign byp_a = '0;
   assign byp_b = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vectors with hand-computed expectations for regfile_writeback
module tb_regfile_writeback;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_hold = 1'b0;
   logic        WrEn;
   logic [4:0]  Aw;
   logic [31:0] Dw;
   logic [4:0]  Rs = 5'd0, Rt = 5'd0;
   logic        hit_a, hit_b;
   logic [31:0] byp_a, byp_b;
   logic [2:0]  count;
   int n_vec = 0;
   int n_bad = 0;
   regfile_writeback_if #(.width(32)) bus ();
   regfile_writeback #(.width(32), .depth(4)) dut (
      .clk(clk), .reset(reset), .in_bus(bus), .wr_hold(wr_hold),
      .WrEn(WrEn), .Aw(Aw), .Dw(Dw), .Rs(Rs), .Rt(Rt),
      .hit_a(hit_a), .hit_b(hit_b), .byp_a(byp_a), .byp_b(byp_b), .count(count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.in_valid = v;
      bus.in_addr  = a;
      bus.in_data  = d;
   endtask
   initial begin
      drive(1'b0, 5'd0, 32'h0);
      #22;
      chk("rst_wren", WrEn, 0);
      chk("rst_aw", Aw, 0);
      chk("rst_dw", Dw, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_hit", {hit_a, hit_b}, 0);
      chk("rst_byp", {byp_a, byp_b}, 0);
      tick();
      reset = 1'b0;
      // single push, 2-edge latency to WrEn
      drive(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      drive(1'b0, 5'd0, 32'h0);
      chk("s_count1", count, 1);
      chk("s_wren0", WrEn, 0);
      tick();
      chk("s_wren1", WrEn, 1);
      chk("s_aw", Aw, 5);
      chk("s_dw", Dw, 32'hDEADBEEF);
      chk("s_count0", count, 0);
      tick();
      chk("s_wren_off", WrEn, 0);
      chk("s_aw_hold", Aw, 5);
      // hold while filling, then drain in order
      wr_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(i + 1), 32'h100 + i);
         tick();
      end
      drive(1'b0, 5'd0, 32'h0);
      chk("f_count", count, 4);
      chk("f_ready", bus.in_ready, 0);
      chk("f_wren", WrEn, 0);
      tick();
      chk("f_hold_wren", WrEn, 0);
      wr_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("f_d_wren", WrEn, 1);
         chk("f_d_aw", Aw, i + 1);
         chk("f_d_dw", Dw, 32'h100 + i);
         if (i == 0) chk("f_ready_again", bus.in_ready, 1);
      end
      tick();
      chk("f_end_wren", WrEn, 0);
      chk("f_end_count", count, 0);
      // write to r0 is accepted and dropped
      drive(1'b1, 5'd0, 32'h1234);
      #1;
      chk("z_ready", bus.in_ready, 1);
      tick();
      drive(1'b0, 5'd0, 32'h0);
      chk("z_count", count, 0);
      tick();
      chk("z_wren", WrEn, 0);
      // bypass: two pending writes to r7
      wr_hold = 1'b1;
      drive(1'b1, 5'd7, 32'h11);
      tick();
      drive(1'b1, 5'd7, 32'h22);
      tick();
      drive(1'b0, 5'd0, 32'h0);
      Rs = 5'd7;
      Rt = 5'd3;
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      chk("b_hit_a", hit_a, 1);
      chk("b_byp_a", byp_a, 32'h22);
`else
      chk("b_hit_a", hit_a, 0);
      chk("b_byp_a", byp_a, 0);
`endif
      chk("b_hit_b", hit_b, 0);
      chk("b_byp_b", byp_b, 0);
      Rs = 5'd0;
      #1;
      chk("b_r0_hit", hit_a, 0);
      Rs = 5'd7;
      wr_hold = 1'b0;
      tick();
      chk("b_d1_aw", Aw, 7);
      chk("b_d1_dw", Dw, 32'h11);
`ifdef REGFILE_WB_BYPASS_EN
      chk("b_young", byp_a, 32'h22);
`endif
      tick();
      chk("b_d2_dw", Dw, 32'h22);
`ifdef REGFILE_WB_BYPASS_EN
      chk("b_out_hit", hit_a, 1);
      chk("b_out_byp", byp_a, 32'h22);
`endif
      tick();
      chk("b_clear_hit", hit_a, 0);
      Rs = 5'd0;
      Rt = 5'd0;
      // streaming push/pop across pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 5'(i + 1), 32'hA000 + i);
         tick();
         chk("t_count", count, 1);
         if (i > 0) begin
            chk("t_wren", WrEn, 1);
            chk("t_aw", Aw, i);
            chk("t_dw", Dw, 32'hA000 + i - 1);
         end
      end
      drive(1'b0, 5'd0, 32'h0);
      tick();
      chk("t_last_dw", Dw, 32'hA000 + 19);
      chk("t_last_count", count, 0);
      // reset mid-drain
      wr_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(i + 9), 32'hB0 + i);
         tick();
      end
      drive(1'b0, 5'd0, 32'h0);
      wr_hold = 1'b0;
      tick();
      chk("r_pre_wren", WrEn, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("r_wren", WrEn, 0);
      chk("r_count", count, 0);
      chk("r_ready", bus.in_ready, 1);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r_after_wren", WrEn, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the 32-entry register file: buffers completed results from the execute stage in a small in-order queue and drains them, one per cycle, onto the register file's single write port (WrEn/Aw/Dw). Holds results while the write port is blocked, discards writes to register 0, and can forward pending values to the register file's Rs/Rt readers so reads never observe stale data.

## Interface
- width, 32: data width; must match the register file.
- depth, 4: queue entries; power of two, 2..16.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  result available on in_addr/in_data.
- in_ready  out  1  queue can accept; a push occurs when in_valid && in_ready at a rising edge.
- in_addr  in  5  destination register.
- in_data  in  width  result value.
- wr_hold  in  1  write port unavailable this cycle; no pop.
- WrEn  out  1  register file write enable (registered).
- Aw  out  5  register file write address (registered).
- Dw  out  width  register file write data (registered).
- Rs  in  5  first read address, monitored for bypass.
- Rt  in  5  second read address, monitored for bypass.
- hit_a / hit_b  out  1  pending write matches Rs / Rt (combinational).
- byp_a / byp_b  out  width  forwarded value for Rs / Rt (combinational).
- count  out  clog2(depth)+1  occupied entries.

## Operation
- Circular queue: write pointer, read pointer, count register; pointers wrap modulo depth.
- in_ready = (count != depth). It does not depend on a same-cycle pop, so a full queue refuses input even when draining.
- Push with in_addr == 0: handshake completes (in_ready honoured), nothing is stored, count unchanged.
- Pop condition: count != 0 && !wr_hold. On pop edge: WrEn<=1, Aw<=head addr, Dw<=head data, read pointer advances, count decrements.
- No pop on an edge: WrEn<=0; Aw/Dw hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Ordering strictly FIFO; two pending writes to the same register both drain, in order.
- Bypass (under macro): compare Rs (and Rt) against every valid queue entry and against the output stage (Aw while WrEn==1). Priority youngest first: newest queue entry, then older entries, then output stage. Rs==0 / Rt==0 never hits. No hit: hit=0, byp=0.

## Timing
- Reset (async, immediate): WrEn=0, Aw=0, Dw=0, count=0, pointers=0, in_ready=1, hit_a=hit_b=0, byp_a=byp_b=0. Reset mid-drain discards all pending entries; no partial write is issued.
- Latency: push at edge N into an empty queue -> WrEn=1 with that data after edge N+1 (given wr_hold low during the cycle before N+1); the register file commits it at edge N+2.
- Throughput: one write per cycle sustained.
- wr_hold is sampled at the pop edge; asserting it for K cycles delays the head by exactly K cycles.
- Full: after depth pushes with no pops, in_ready=0 from the following cycle; it reasserts the cycle after the first pop.
- Bypass outputs are combinational from Rs/Rt and current state; they are valid in the same cycle.

## Configuration
- REGFILE_WB_BYPASS_EN defined: comparators and forwarding muxes present, behaviour as above.
- Undefined: hit_a=hit_b=0 and byp_a=byp_b=0 constantly; no compare logic is synthesised; the pipeline must stall reads against pending writes.

## Test plan
- Reset then single push (addr 5, 0xDEADBEEF) at edge 1 -> WrEn=1, Aw=5, Dw=0xDEADBEEF after edge 2, WrEn=0 after edge 3, count back to 0.
- wr_hold=1 throughout, push 4 entries -> count=4, in_ready=0, WrEn stays 0; release hold -> 4 consecutive WrEn cycles in push order, in_ready=1 the cycle after the first pop.
- Push addr 0 with data 0x1234 -> handshake accepted, count stays 0, WrEn never asserts.
- With bypass enabled, wr_hold=1: push r7=0x11 then r7=0x22; Rs=7 -> hit_a=1, byp_a=0x22; Rt=3 -> hit_b=0, byp_b=0; Rs=0 -> hit_a=0.
- Continuous push/pop with wr_hold=0 for 20 items crossing pointer wrap -> all 20 written in order, count never exceeds 1.
- Fill 3 entries, assert reset mid-drain -> WrEn=0, count=0, in_ready=1 immediately; no further writes after release.
